// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data memory slice.
//   SZ_*    : access size field carried on i_size
//   state_t : controller state (zero-fill sweep, then serving requests)
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/mips_dmem_lane.sv
// Byte-lane steering for the data memory (purely combinational).
//   size        : access size (SZ_BYTE..SZ_DWORD)
//   offset      : byte offset of the access inside the memory word
//   is_unsigned : zero-extend (1) or sign-extend (0) load results
//   wdata       : right-justified store data
//   rword       : raw memory word currently addressed
//   byte_en     : lanes written by a store
//   wdata_lane  : store data shifted into its lanes
//   rdata_ext   : selected lanes, right-justified and extended
//   bad         : misaligned access or size wider than the memory word
module mips_dmem_lane
    import mips_mem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic [1:0]            size,
    input  logic [OFF_W-1:0]      offset,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rword,
    output logic [NB-1:0]         byte_en,
    output logic [DATA_WIDTH-1:0] wdata_lane,
    output logic [DATA_WIDTH-1:0] rdata_ext,
    output logic                  bad
);

    int                    nbytes;
    int                    nbits;
    int                    off_i;
    logic                  illegal;
    logic                  misalign;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        nbytes     = 1 << size;
        off_i      = int'(offset);
        // Natural alignment: offset must be a multiple of the access size.
        misalign   = (off_i & (nbytes - 1)) != 0;
        illegal    = (size == SZ_DWORD) && (DATA_WIDTH < 64);
        bad        = misalign || illegal;

        byte_en    = '0;
        for (int k = 0; k < NB; k++) begin
            byte_en[k] = (k >= off_i) && (k < off_i + nbytes);
        end
        wdata_lane = wdata << (8 * off_i);

        // Clamp so an illegal dword on a 32-bit memory never indexes past the word.
        nbits      = (nbytes * 8 > DATA_WIDTH) ? DATA_WIDTH : nbytes * 8;
        shifted    = rword >> (8 * off_i);
        sign_bit   = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i == nbits - 1) sign_bit = shifted[i] & ~is_unsigned;
        end
        rdata_ext  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            rdata_ext[i] = (i < nbits) ? shifted[i] : sign_bit;
        end
    end

endmodule

// File: rtl/mips_dmem.sv
// Byte-addressed single-port data memory with sized, extended loads.
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_req, i_we    : request strobe and store/load select
//   i_addr, i_size : byte address and access size
//   i_unsigned     : zero-extend loads when 1
//   i_wdata        : right-justified store data
//   o_ready        : block is accepting requests
//   o_rvalid       : one-cycle response pulse (load data or error)
//   o_err          : response is an error (misaligned or illegal size)
//   o_rdata        : load result, holds when o_rvalid is low
//
// Handshake: a request is taken on a rising edge where i_req && o_ready;
// there is no backpressure once ready. Loads and faulting accesses answer
// exactly one cycle later with a single o_rvalid pulse; good stores answer
// nothing. Requests while o_ready is low are dropped silently.
module mips_dmem
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_ready,
    output logic                  o_rvalid,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = ADDR_WIDTH - OFF_W;
    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    logic [IDX_W-1:0]      sweep_cnt;
    logic [IDX_W-1:0]      word_idx;
    logic [OFF_W-1:0]      offset;
    logic                  accept;
    logic                  sweep_we;
    logic                  store_we;
    logic [NB-1:0]         byte_en;
    logic [DATA_WIDTH-1:0] wdata_lane;
    logic [DATA_WIDTH-1:0] rdata_ext;
    logic                  bad;

    assign word_idx = i_addr[ADDR_WIDTH-1:OFF_W];
    assign offset   = i_addr[OFF_W-1:0];
    assign o_ready  = (state == ST_READY);
    assign accept   = i_req && o_ready;
    assign store_we = accept && i_we && !bad;
    // Gate with reset so the sweep cannot touch memory while held in reset.
    assign sweep_we = (INIT_ZERO != 0) && (state == ST_INIT) && i_rst_n;

    mips_dmem_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .size        (i_size),
        .offset      (offset),
        .is_unsigned (i_unsigned),
        .wdata       (i_wdata),
        .rword       (mem[word_idx]),
        .byte_en     (byte_en),
        .wdata_lane  (wdata_lane),
        .rdata_ext   (rdata_ext),
        .bad         (bad)
    );

    // Storage has no reset; it is cleared by the sweep instead.
    always_ff @(posedge i_clk) begin
        if (sweep_we) begin
            mem[sweep_cnt] <= '0;
        end else if (store_we) begin
            for (int k = 0; k < NB; k++) begin
                if (byte_en[k]) mem[word_idx][8*k +: 8] <= wdata_lane[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
            o_rvalid  <= 1'b0;
            o_err     <= 1'b0;
            o_rdata   <= '0;
        end else begin
            o_rvalid <= 1'b0;
            o_err    <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (INIT_ZERO == 0) begin
                        state <= ST_READY;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                        if (sweep_cnt == IDX_W'(DEPTH - 1)) state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (accept) begin
                        if (bad) begin
                            o_rvalid <= 1'b1;
                            o_err    <= 1'b1;
                            o_rdata  <= '0;
                        end else if (!i_we) begin
                            o_rvalid <= 1'b1;
                            o_rdata  <= rdata_ext;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem.sv
module tb_mips_dmem;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 256;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_req;
    logic          i_we;
    logic [AW-1:0] i_addr;
    logic [1:0]    i_size;
    logic          i_unsigned;
    logic [DW-1:0] i_wdata;
    logic          o_ready;
    logic          o_rvalid;
    logic          o_err;
    logic [DW-1:0] o_rdata;

    mips_dmem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_ZERO(1)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_size     (i_size),
        .i_unsigned (i_unsigned),
        .i_wdata    (i_wdata),
        .o_ready    (o_ready),
        .o_rvalid   (o_rvalid),
        .o_err      (o_err),
        .o_rdata    (o_rdata)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    logic [7:0]    ref_mem [1 << AW];   // byte-addressed image of the memory
    logic [32:0]   exp_q[$];            // {err, data} of responses due next cycle
    int            edges;               // rising edges since reset release
    bit            mdl_ready;
    logic [DW-1:0] last_rdata;
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_load(input int addr, input int nb, input bit uns);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < nb; b++) v = v | (64'(ref_mem[addr + b]) << (8 * b));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
        return v[31:0];
    endfunction

    task automatic model_reset();
        for (int a = 0; a < (1 << AW); a++) ref_mem[a] = 8'h00;
        exp_q.delete();
        edges      = 0;
        mdl_ready  = 0;
        last_rdata = '0;
    endtask

    // ---------------- driver: one request per clock, checked next cycle ----------------
    task automatic step(input bit req, input bit we, input logic [AW-1:0] addr,
                        input logic [1:0] size, input bit uns, input logic [DW-1:0] wdata);
        int          nb;
        bit          bad;
        logic [32:0] e;
        i_req = req; i_we = we; i_addr = addr; i_size = size;
        i_unsigned = uns; i_wdata = wdata;
        nb  = 1 << size;
        bad = (size == 2'd3) || ((int'(addr) % nb) != 0);
        if (req && mdl_ready) begin
            if (bad)      exp_q.push_back({1'b1, 32'h0});
            else if (we)  for (int b = 0; b < nb; b++) ref_mem[int'(addr) + b] = wdata[8*b +: 8];
            else          exp_q.push_back({1'b0, mdl_load(int'(addr), nb, uns)});
        end
        @(posedge i_clk);
        edges++;
        mdl_ready = (edges >= DEPTH);
        @(negedge i_clk);
        i_req = 1'b0;
        check("ready", 64'(o_ready), 64'(mdl_ready));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rvalid", 64'(o_rvalid), 64'd1);
            check("err",    64'(o_err),    64'(e[32]));
            check("rdata",  64'(o_rdata),  64'(e[31:0]));
            last_rdata = e[31:0];
        end else begin
            check("rvalid_idle", 64'(o_rvalid), 64'd0);
            check("rdata_hold",  64'(o_rdata),  64'(last_rdata));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 2'd0, 0, '0);
    endtask

    task automatic rand_step(input bit in_init);
        logic [AW-1:0] a;
        logic [1:0]    sz;
        sz = 2'($urandom_range(0, 3));
        a  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) a = a & ~AW'((1 << sz) - 1);
        step(($urandom_range(0, 9) < (in_init ? 3 : 8)), 1'($urandom_range(0, 1)), a, sz,
             1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready"},  64'(o_ready),  64'd0);
        check({tag, "_rvalid"}, 64'(o_rvalid), 64'd0);
        check({tag, "_err"},    64'(o_err),    64'd0);
        check({tag, "_rdata"},  64'(o_rdata),  64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_fail = 0;
        i_rst_n = 1'b0; i_req = 0; i_we = 0; i_addr = '0; i_size = '0;
        i_unsigned = 0; i_wdata = '0;
        model_reset();
        #12;
        check_cleared("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Sweep: ready stays low 256 cycles (a request mid-sweep is dropped).
        idle(50);
        step(1, 0, 10'h000, 2'd2, 0, '0);
        idle(DEPTH - 51);
        check("ready_after_sweep", 64'(o_ready), 64'd1);

        step(1, 0, 10'h3FC, 2'd2, 0, '0);
        check("ld_3fc", 64'(o_rdata), 64'h0);
        check("ld_3fc_err", 64'(o_err), 64'd0);

        step(1, 1, 10'h100, 2'd2, 0, 32'hDEADBEEF);
        step(1, 0, 10'h101, 2'd0, 0, '0);
        check("lb_101", 64'(o_rdata), 64'hFFFFFFBE);
        step(1, 0, 10'h101, 2'd0, 1, '0);
        check("lbu_101", 64'(o_rdata), 64'h000000BE);
        step(1, 0, 10'h102, 2'd1, 0, '0);
        check("lh_102", 64'(o_rdata), 64'hFFFFDEAD);
        step(1, 0, 10'h102, 2'd1, 1, '0);
        check("lhu_102", 64'(o_rdata), 64'h0000DEAD);

        step(1, 1, 10'h103, 2'd0, 0, 32'h00000012);
        step(1, 0, 10'h100, 2'd2, 0, '0);
        check("lw_100_a", 64'(o_rdata), 64'h12ADBEEF);

        step(1, 0, 10'h101, 2'd1, 0, '0);
        check("lh_mis_err", 64'(o_err), 64'd1);
        step(1, 1, 10'h102, 2'd2, 0, 32'hFFFFFFFF);
        check("sw_mis_err", 64'(o_err), 64'd1);
        step(1, 0, 10'h100, 2'd2, 0, '0);
        check("lw_100_b", 64'(o_rdata), 64'h12ADBEEF);
        step(1, 0, 10'h000, 2'd3, 0, '0);
        check("ld_size3_err", 64'(o_err), 64'd1);

        step(1, 1, 10'h004, 2'd2, 0, 32'h11223344);
        step(1, 0, 10'h004, 2'd2, 0, '0);
        check("lw_004_b2b", 64'(o_rdata), 64'h11223344);
        step(1, 0, 10'h100, 2'd2, 0, '0);
        step(1, 0, 10'h004, 2'd1, 0, '0);
        step(1, 0, 10'h103, 2'd0, 1, '0);
        step(1, 0, 10'h3FC, 2'd2, 0, '0);
        idle(1);

        for (int i = 0; i < 400; i++) rand_step(0);
        idle(1);

        // Reset while a load response is on the outputs.
        @(negedge i_clk);
        i_req = 1; i_we = 0; i_addr = 10'h004; i_size = 2'd2; i_unsigned = 0;
        @(posedge i_clk);
        #2;
        i_req = 0;
        check("pre_rst_rvalid", 64'(o_rvalid), 64'd1);
        check("pre_rst_ready",  64'(o_ready),  64'd1);
        i_rst_n = 1'b0;
        #1;
        check_cleared("rst_resp");
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Reset with the sweep counter at 100; the sweep must restart from zero.
        for (int i = 0; i < 100; i++) rand_step(1);
        i_rst_n = 1'b0;
        #1;
        check_cleared("rst_sweep");
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) rand_step(1);
        check("ready_after_resweep", 64'(o_ready), 64'd1);
        for (int i = 0; i < 150; i++) rand_step(0);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
